// File: rtl/pin_verifier_if.sv
// Keypad, reference PIN and verdict signals between the keypad front end and pin_verifier.
// The slave side is the verifier; all verdict outputs are registered inside it.
interface pin_verifier_if #(
    parameter int DIGITS = 4
);
    logic                  card;
    logic                  key_valid;
    logic [3:0]            key_digit;
    logic                  key_enter;
    logic                  key_clear;
    logic [4*DIGITS-1:0]   pin_ref;
    logic                  pin_ok;
    logic                  pin_fail;
    logic                  card_retain;
    logic [1:0]            tries_left;
    logic [2:0]            digit_count;

    modport master (
        output card, key_valid, key_digit, key_enter, key_clear, pin_ref,
        input  pin_ok, pin_fail, card_retain, tries_left, digit_count
    );

    modport slave (
        input  card, key_valid, key_digit, key_enter, key_clear, pin_ref,
        output pin_ok, pin_fail, card_retain, tries_left, digit_count
    );
endinterface

// File: rtl/pin_verifier.sv
// PIN entry/verification ahead of the ATM transaction FSM: collects BCD digits, grants or counts failures, retains card.
// Enter asserted after edge N: CHECK after edge N+1, pin_ok/pin_fail after edge N+2; no backpressure, keys are strobes.
module pin_verifier #(
    parameter int DIGITS         = 4,
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic           clock,
    input  logic           reset,
    pin_verifier_if.slave  bus
);
    localparam int              BW         = 4 * DIGITS;
    localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      TRIES_INIT = 2'(MAX_TRIES);
    localparam logic [2:0]      DIG_FULL   = 3'(DIGITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_GRANTED,
        S_LOCKED
    } state_t;

    state_t         r_state;
    logic [BW-1:0]  r_buf;
    logic [2:0]     r_count;
    logic [TW-1:0]  r_tmo;
    logic           r_timed_out;
    logic           r_pin_ok;
    logic           r_pin_fail;
    logic           r_card_retain;
    logic [1:0]     r_tries;

    logic           w_digit_ok;
    logic           w_match;
    logic           w_tmo_hit;
    logic [1:0]     w_tries_dec;

    assign w_digit_ok  = bus.key_valid && (bus.key_digit <= 4'd9) && (r_count < DIG_FULL);
    // A timed-out entry must fail even if the buffer already holds the right PIN.
    assign w_match     = !r_timed_out && (r_count == DIG_FULL) && (r_buf == bus.pin_ref);
    assign w_tmo_hit   = (r_tmo == TMO_LAST);
    assign w_tries_dec = (r_tries != 2'd0) ? (r_tries - 2'd1) : 2'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_buf         <= '0;
            r_count       <= 3'd0;
            r_tmo         <= '0;
            r_timed_out   <= 1'b0;
            r_pin_ok      <= 1'b0;
            r_pin_fail    <= 1'b0;
            r_card_retain <= 1'b0;
            r_tries       <= TRIES_INIT;
        end else begin
            r_pin_fail <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_pin_ok <= 1'b0;
                    if (bus.card) begin
                        r_state     <= S_ENTRY;
                        r_tries     <= TRIES_INIT;
                        r_buf       <= '0;
                        r_count     <= 3'd0;
                        r_tmo       <= '0;
                        r_timed_out <= 1'b0;
                    end
                end

                S_ENTRY: begin
                    if (!bus.card) begin
                        r_state <= S_IDLE;
                        r_buf   <= '0;
                        r_count <= 3'd0;
                        r_tmo   <= '0;
                        r_tries <= TRIES_INIT;
                    end else if (bus.key_clear) begin
                        r_buf   <= '0;
                        r_count <= 3'd0;
                        r_tmo   <= '0;
                    end else if (bus.key_enter) begin
                        r_state <= S_CHECK;
                        r_tmo   <= '0;
                    end else if (w_digit_ok) begin
                        r_buf   <= (r_buf << 4) | BW'(bus.key_digit);
                        r_count <= r_count + 3'd1;
                        r_tmo   <= '0;
                    end else if (w_tmo_hit) begin
                        r_state     <= S_CHECK;
                        r_timed_out <= 1'b1;
                        r_tmo       <= '0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end

                S_CHECK: begin
                    r_timed_out <= 1'b0;
                    if (!bus.card) begin
                        r_state <= S_IDLE;
                        r_buf   <= '0;
                        r_count <= 3'd0;
                        r_tmo   <= '0;
                        r_tries <= TRIES_INIT;
                    end else if (w_match) begin
                        r_state  <= S_GRANTED;
                        r_pin_ok <= 1'b1;
                    end else begin
                        r_pin_fail <= 1'b1;
                        r_tries    <= w_tries_dec;
                        r_buf      <= '0;
                        r_count    <= 3'd0;
                        r_tmo      <= '0;
                        if (w_tries_dec == 2'd0) begin
                            r_state       <= S_LOCKED;
                            r_card_retain <= 1'b1;
                        end else begin
                            r_state <= S_ENTRY;
                        end
                    end
                end

                S_GRANTED: begin
                    if (!bus.card) begin
                        r_state  <= S_IDLE;
                        r_pin_ok <= 1'b0;
                        r_buf    <= '0;
                        r_count  <= 3'd0;
                    end
                end

                S_LOCKED: begin
                    r_card_retain <= 1'b1;
                    r_pin_ok      <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pin_ok      = r_pin_ok;
    assign bus.pin_fail    = r_pin_fail;
    assign bus.card_retain = r_card_retain;
    assign bus.tries_left  = r_tries;
    assign bus.digit_count = r_count;
endmodule
